// File: rtl/car_motion_unit_if.sv
// Handshake and status bundle between the call controller and the car motion unit.
// The controller side drives the target request and the in-car hold button;
// the motion unit reports its position, travel state and arrival pulses.
interface car_motion_unit_if;
    logic [2:0] target_floor;
    logic       target_valid;
    logic       target_ready;
    logic       door_hold;
    logic [2:0] current_floor;
    logic       direction;
    logic       moving;
    logic       door_open;
    logic       arrived;
    logic [2:0] arrived_floor;

    modport master (
        output target_floor,
        output target_valid,
        output door_hold,
        input  target_ready,
        input  current_floor,
        input  direction,
        input  moving,
        input  door_open,
        input  arrived,
        input  arrived_floor
    );

    modport slave (
        input  target_floor,
        input  target_valid,
        input  door_hold,
        output target_ready,
        output current_floor,
        output direction,
        output moving,
        output door_open,
        output arrived,
        output arrived_floor
    );
endinterface

// File: rtl/car_motion_unit.sv
// Car motion unit: accepts one target floor at a time, travels there one floor
// per FLOOR_CYCLES clocks, pulses arrived on reaching it, then runs the door
// through an open period (extendable by door_hold) and a short closing phase.
// All outputs come from registers or are decoded from the registered state.
module car_motion_unit #(
    parameter int FLOOR_CYCLES = 8,
    parameter int DOOR_CYCLES  = 16
) (
    input logic            clk,
    input logic            reset,
    car_motion_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR_OPEN,
        DOOR_CLOSE
    } state_t;

    localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST  = 8'(DOOR_CYCLES - 1);

    state_t     state;
    logic [7:0] travel_cnt;
    logic [7:0] door_cnt;
    logic [2:0] target;
    logic [2:0] current_floor;
    logic [2:0] arrived_floor;
    logic       direction;
    logic       arrived;
    logic [2:0] next_floor;

    // Floor the car reaches at the end of the current floor interval.
    always_comb begin
        next_floor = direction ? (current_floor + 3'd1) : (current_floor - 3'd1);
    end

    // Main FSM: request acceptance, floor stepping, door timing and arrival pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            travel_cnt    <= 8'd0;
            door_cnt      <= 8'd0;
            target        <= 3'd0;
            current_floor <= 3'd0;
            arrived_floor <= 3'd0;
            direction     <= 1'b1;
            arrived       <= 1'b0;
        end else begin
            arrived <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.target_valid) begin
                        if (bus.target_floor == current_floor) begin
                            state         <= DOOR_OPEN;
                            arrived       <= 1'b1;
                            arrived_floor <= current_floor;
                            door_cnt      <= 8'd0;
                        end else begin
                            target     <= bus.target_floor;
                            direction  <= (bus.target_floor > current_floor);
                            travel_cnt <= 8'd0;
                            state      <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (travel_cnt == FLOOR_LAST) begin
                        travel_cnt    <= 8'd0;
                        current_floor <= next_floor;
                        if (next_floor == target) begin
                            state         <= DOOR_OPEN;
                            arrived       <= 1'b1;
                            arrived_floor <= target;
                            door_cnt      <= 8'd0;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + 8'd1;
                    end
                end
                DOOR_OPEN: begin
                    if (bus.door_hold) begin
                        door_cnt <= 8'd0;
                    end else if (door_cnt == DOOR_LAST) begin
                        door_cnt <= 8'd0;
                        state    <= DOOR_CLOSE;
                    end else begin
                        door_cnt <= door_cnt + 8'd1;
                    end
                end
                DOOR_CLOSE: begin
                    if (bus.door_hold) begin
                        door_cnt <= 8'd0;
                        state    <= DOOR_OPEN;
                    end else if (door_cnt == 8'd1) begin
                        door_cnt <= 8'd0;
                        state    <= IDLE;
                    end else begin
                        door_cnt <= door_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.target_ready  = (state == IDLE);
    assign bus.moving        = (state == MOVE);
    assign bus.door_open     = (state == DOOR_OPEN);
    assign bus.current_floor = current_floor;
    assign bus.direction     = direction;
    assign bus.arrived       = arrived;
    assign bus.arrived_floor = arrived_floor;

endmodule

// File: tb/tb_car_motion_unit.sv
// Scoreboard bench for car_motion_unit: each accepted trip pushes its expected
// floor-step, arrival and door events; a monitor compares them as they appear.
module tb_car_motion_unit;

    localparam int FC = 4;
    localparam int DC = 4;

    typedef struct {
        int         cyc;
        logic [2:0] floor;
        logic       arr;
        logic [2:0] af;
        logic       door;
        logic       mov;
        logic       rdy;
        logic       dir;
        logic       chk_af;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    bit   mon_en = 1'b0;
    ev_t  sb[$];

    car_motion_unit_if bus();

    car_motion_unit #(.FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock and edge counter used to time every expected event.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkEv(input int c, input logic [2:0] f, input logic arr,
                                 input logic [2:0] af, input logic door, input logic mov,
                                 input logic rdy, input logic dir, input logic chk_af);
        ev_t e;
        e.cyc = c; e.floor = f; e.arr = arr; e.af = af; e.door = door;
        e.mov = mov; e.rdy = rdy; e.dir = dir; e.chk_af = chk_af;
        return e;
    endfunction

    function automatic ev_t sampleDut();
        return mkEv(cyc, bus.current_floor, bus.arrived, bus.arrived_floor, bus.door_open,
                    bus.moving, bus.target_ready, bus.direction, 1'b1);
    endfunction

    task automatic checkOutput(input string name, input ev_t exp, input ev_t act);
        bit ok;
        ok = (act.cyc == exp.cyc) && (act.floor === exp.floor) && (act.arr === exp.arr) &&
             (act.door === exp.door) && (act.mov === exp.mov) && (act.rdy === exp.rdy) &&
             (act.dir === exp.dir) && (!exp.chk_af || (act.af === exp.af));
        n_compared++;
        if (!ok) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got cyc=%0d floor=%0d arr=%0b af=%0d door=%0b mov=%0b rdy=%0b dir=%0b, want cyc=%0d floor=%0d arr=%0b af=%0d door=%0b mov=%0b rdy=%0b dir=%0b",
                     name, act.cyc, act.floor, act.arr, act.af, act.door, act.mov, act.rdy, act.dir,
                     exp.cyc, exp.floor, exp.arr, exp.af, exp.door, exp.mov, exp.rdy, exp.dir);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0b, want %0b (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Wait at negedges until the edge counter reaches c (always at least one negedge).
    task automatic waitNeg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Offer a target once the unit is idle; acc returns the accepting edge number.
    task automatic applyStimulus(input logic [2:0] floor, output int acc);
        int waited = 0;
        @(negedge clk);
        while (bus.target_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.target_ready !== 1'b1) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL ready_timeout: got target_ready=%0b, want 1 within 100 cycles", bus.target_ready);
            acc = -1;
            return;
        end
        bus.target_floor = floor;
        bus.target_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.target_valid = 1'b0;
    endtask

    task automatic pushTrip(input int acc, input int from, input int to);
        int   n;
        logic dir;
        bit   last;
        dir = (to > from);
        n = dir ? (to - from) : (from - to);
        for (int k = 1; k <= n; k++) begin
            last = (k == n);
            sb.push_back(mkEv(acc + k * FC, 3'(dir ? from + k : from - k), last, 3'(to),
                              last, !last, 1'b0, dir, last));
        end
        sb.push_back(mkEv(acc + n * FC + DC, 3'(to), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, dir, 1'b0));
    endtask

    task automatic pushSameFloor(input int acc, input int fl, input logic dir);
        sb.push_back(mkEv(acc, 3'(fl), 1'b1, 3'(fl), 1'b1, 1'b0, 1'b0, dir, 1'b1));
        sb.push_back(mkEv(acc + DC, 3'(fl), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, dir, 1'b0));
    endtask

    // Monitor: any floor change, arrival pulse or door edge must match the next expected event.
    initial begin
        logic [2:0] prev_floor;
        logic       prev_door;
        ev_t        act;
        ev_t        exp;
        prev_floor = 3'd0;
        prev_door  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && (bus.current_floor !== prev_floor || bus.arrived === 1'b1 ||
                           bus.door_open !== prev_door)) begin
                act = sampleDut();
                if (sb.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_event: got cyc=%0d floor=%0d arr=%0b door=%0b, want no event",
                             act.cyc, act.floor, act.arr, act.door);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("event", exp, act);
                end
            end
            prev_floor = bus.current_floor;
            prev_door  = bus.door_open;
        end
    end

    // Global safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        int acc;
        int a;
        int waited;
        bus.target_floor = 3'd0;
        bus.target_valid = 1'b0;
        bus.door_hold    = 1'b0;
        reset            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("reset_state", mkEv(3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), sampleDut());
        mon_en = 1'b1;

        $display("[TB] trip 0 -> 3 with target requests ignored while busy");
        applyStimulus(3'd3, acc);
        pushTrip(acc, 0, 3);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.target_valid = (i % 2 == 0);
            bus.target_floor = 3'(6 - (i % 3));
            checkBit("ready_busy", bus.target_ready, 1'b0);
        end
        bus.target_valid = 1'b0;

        $display("[TB] trip 3 -> 0");
        applyStimulus(3'd0, acc);
        pushTrip(acc, 3, 0);

        $display("[TB] trips 0 -> 6 -> 5, then request own floor 5");
        applyStimulus(3'd6, acc);
        pushTrip(acc, 0, 6);
        applyStimulus(3'd5, acc);
        pushTrip(acc, 6, 5);
        applyStimulus(3'd5, acc);
        pushSameFloor(acc, 5, 1'b0);

        $display("[TB] door hold in open and closing phases");
        applyStimulus(3'd5, acc);
        a = acc;
        sb.push_back(mkEv(a,      3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        sb.push_back(mkEv(a + 7,  3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(mkEv(a + 8,  3'd5, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(mkEv(a + 12, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        waitNeg(a + 2);
        bus.door_hold = 1'b1;
        waitNeg(a + 3);
        bus.door_hold = 1'b0;
        waitNeg(a + 7);
        bus.door_hold = 1'b1;
        waitNeg(a + 8);
        bus.door_hold = 1'b0;

        $display("[TB] reset during trip 5 -> 0 at floor 4");
        applyStimulus(3'd0, acc);
        sb.push_back(mkEv(acc + 4, 3'd4, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(mkEv(acc + 6, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        waitNeg(acc + 5);
        reset = 1'b0;
        waitNeg(acc + 6);
        reset = 1'b1;
        checkBit("ready_after_reset", bus.target_ready, 1'b1);
        checkBit("moving_after_reset", bus.moving, 1'b0);

        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkInt("events_outstanding", sb.size(), 0);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
